alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX pipeline register feeding the 16-bit ALU. Latches decoded operands, maps the
//  4-bit opcode to the 3-bit ALUOp, resolves EX/MEM and MEM/WB forwarding onto the ALU
//  inputs, and owns the architectural flag register {N,V,Z} written from the ALU flag
//  outputs under per-opcode update masks. Sits between decode and the ALU.
// PARAMETERS
//  DW    16  datapath width (ALU is fixed at 16; only 16 is supported)
//  RW    4   register-specifier width (16 registers, R0 reads as zero)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  stall           in   1   hold ID/EX contents this cycle
//  flush           in   1   replace the incoming instruction with a bubble
//  id_valid        in   1   decode stage holds a real instruction
//  id_opcode       in   4   0 ADD,1 SUB,2 XOR,3 RED,4 SLL,5 SRA,6 ROR,7 PADDSB, 8-15 non-ALU
//  id_rs, id_rt    in   4   source specifiers
//  id_rd           in   4   destination specifier
//  id_rs_data      in   16  register-file read of rs
//  id_rt_data      in   16  register-file read of rt
//  id_imm          in   16  sign/zero-extended immediate from decode
//  id_use_imm      in   1   ALU operand 2 is the immediate
//  id_reg_write    in   1   instruction writes rd
//  exmem_reg_write in   1   EX/MEM writes a register;  exmem_rd in 4; exmem_result in 16
//  memwb_reg_write in   1   MEM/WB writes a register;  memwb_rd in 4; memwb_result in 16
//  alu_flags       in   3   ALU flag outputs {N,V,Z} for the instruction currently in EX
//  alu_in1         out  16  ALU operand 1 (forwarded rs)
//  alu_in2         out  16  ALU operand 2 (immediate or forwarded rt)
//  alu_op          out  3   ALUOp: 000 ADD,001 SUB,010 RED,011 XOR,100 SLL,101 SRA,110 ROR,111 PADDSB
//  ex_valid        out  1   EX holds a real instruction
//  ex_rd           out  4   registered destination;  ex_reg_write out 1 (gated by ex_valid)
//  flag_reg        out  3   architectural {N,V,Z}
// BEHAVIOUR
//  Reset: every register 0: ex_valid=0, ex_reg_write=0, ex_rd=0, alu_op=000, held data=0,
//   flag_reg=3'b000. rst mid-instruction discards it; no flag write on that edge.
//  Register update (rising edge, priority): flush > stall > load.
//   flush: ex_valid<=0, ex_reg_write<=0, other fields don't-care (bubble), even if stall=1.
//   stall: all fields hold, except write-back capture (below).
//   load: capture all id_* fields; ex_valid<=id_valid; ex_reg_write<=id_valid&id_reg_write.
//  Write-back capture: while stalled, if memwb_reg_write && memwb_rd!=0 and equals the held
//   rs (rt), held rs_data (rt_data) <= memwb_result so the value survives MEM/WB retiring.
//  Opcode map: 0->000, 1->001, 2->011, 3->010, 4->100, 5->101, 6->110, 7->111,
//   8-15 ->000 (address/pass-through ADD), registered with the instruction.
//  Forwarding (combinational, per source s in {rs,rt}): s==0 -> 16'h0000; else if
//   exmem_reg_write && exmem_rd==s -> exmem_result; else if memwb_reg_write && memwb_rd==s
//   -> memwb_result; else held register data. EX/MEM wins over MEM/WB.
//  alu_in2 = held id_use_imm ? held imm : forwarded rt. No forwarding applied to the immediate.
//  Flag register: written on an edge only when ex_valid && !stall && !rst. Masks by opcode:
//   ADD,SUB: N,V,Z all updated; XOR,SLL,SRA,ROR: Z only, N/V hold; RED,PADDSB,8-15: none.
//   Bubbles never write flags. Flush does not cancel the flag write of the instruction
//   already in EX (flush affects only the incoming slot).
//  Latency: one cycle decode->EX; forwarding and alu_in* are zero-cycle from EX contents.
// TESTING
//  Reset: assert rst async mid-cycle with ex_valid=1 -> all outputs 0 immediately, flag_reg=000.
//  ADD R3,R1,R2 with rs_data=16'h7FFF, rt_data=16'h0001, alu_flags=3'b110 -> alu_op=000,
//   alu_in1=7FFF, alu_in2=0001, next edge flag_reg=110; following XOR with flags 001 -> flag_reg=111.
//  Forward priority: rs=5, exmem_rd=5 result=1234, memwb_rd=5 result=ABCD -> alu_in1=1234;
//   drop exmem_reg_write -> ABCD; rs=0 with exmem_rd=0 -> alu_in1=0000.
//  Stall 3 cycles holding SUB rs=4; memwb writes R4=00AA in cycle 2 -> after release alu_in1=00AA
//   with no forwarding active; flag_reg unchanged during stall, updates once on release.
//  Flush with stall=1 and id_valid=1 -> ex_valid=0, ex_reg_write=0; next cycle no flag write.
//  RED / PADDSB (opcodes 3,7) with alu_flags=111 -> alu_op 010/111, flag_reg unchanged.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX register for the 16-bit ALU: opcode map, operand forwarding,
// write-back capture while stalled, and the masked {N,V,Z} flag register.
module alu_issue_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_opcode,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_reg_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    input  logic [2:0]    alu_flags,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_op,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic [2:0]    flag_reg
);

    logic [RW-1:0] rs_q, rt_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic          use_imm_q;
    logic [3:0]    opcode_q;
    logic [2:0]    op_map;
    logic [2:0]    flag_mask;
    logic [DW-1:0] fwd_rs, fwd_rt;
    logic          cap_rs, cap_rt;

    always_comb begin
        op_map = 3'b000;
        case (id_opcode)
            4'd0:    op_map = 3'b000;
            4'd1:    op_map = 3'b001;
            4'd2:    op_map = 3'b011;
            4'd3:    op_map = 3'b010;
            4'd4:    op_map = 3'b100;
            4'd5:    op_map = 3'b101;
            4'd6:    op_map = 3'b110;
            4'd7:    op_map = 3'b111;
            default: op_map = 3'b000;
        endcase
    end

    // Bit order {N,V,Z}; logic/shift ops only touch Z
    always_comb begin
        flag_mask = 3'b000;
        case (opcode_q)
            4'd0, 4'd1:             flag_mask = 3'b111;
            4'd2, 4'd4, 4'd5, 4'd6: flag_mask = 3'b001;
            default:                flag_mask = 3'b000;
        endcase
    end

    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] s,
        input logic [DW-1:0] held
    );
        if (s == '0)
            return '0;
        else if (exmem_reg_write && exmem_rd == s)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd == s)
            return memwb_result;
        else
            return held;
    endfunction

    assign fwd_rs  = fwd(rs_q, rs_data_q);
    assign fwd_rt  = fwd(rt_q, rt_data_q);
    assign alu_in1 = fwd_rs;
    assign alu_in2 = use_imm_q ? imm_q : fwd_rt;

    // A stalled instruction must not lose a value that retires from MEM/WB meanwhile
    assign cap_rs = memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q;
    assign cap_rt = memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
            opcode_q     <= '0;
            alu_op       <= 3'b000;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (stall) begin
            if (cap_rs) rs_data_q <= memwb_result;
            if (cap_rt) rt_data_q <= memwb_result;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid & id_reg_write;
            ex_rd        <= id_rd;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            use_imm_q    <= id_use_imm;
            opcode_q     <= id_opcode;
            alu_op       <= op_map;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flag_reg <= 3'b000;
        else if (ex_valid && !stall)
            flag_reg <= (flag_reg & ~flag_mask) | (alu_flags & flag_mask);
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: vector table for opcode map and
// forwarding, hand sequences for flags, reset, stall capture and flush.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [3:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_result, memwb_result;
    logic [2:0]  alu_flags;
    logic [15:0] alu_in1, alu_in2;
    logic [2:0]  alu_op, flag_reg;
    logic        ex_valid, ex_reg_write;
    logic [3:0]  ex_rd;

    int n_pass = 0;
    int n_total = 0;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .alu_flags(alu_flags),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .flag_reg(flag_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rs, rt;
        logic [15:0] rsd, rtd, imm;
        logic        use_imm;
        logic        exw;
        logic [3:0]  exrd;
        logic [15:0] exres;
        logic        mww;
        logic [3:0]  mwrd;
        logic [15:0] mwres;
        logic [2:0]  e_op;
        logic [15:0] e_in1, e_in2;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [3:0] rd,
                        input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic v);
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = 16'h0;
        id_use_imm = 1'b0; id_valid = v; id_reg_write = 1'b1;
    endtask

    task automatic fwd_off();
        exmem_reg_write = 1'b0; exmem_rd = 4'd0; exmem_result = 16'h0;
        memwb_reg_write = 1'b0; memwb_rd = 4'd0; memwb_result = 16'h0;
    endtask

    initial begin
        //       op    rs    rt    rsd       rtd       imm       ui
        //       exw   exrd  exres     mww   mwrd  mwres     e_op    in1       in2
        vt[0]  = '{4'd0, 4'd5, 4'd6, 16'h1111, 16'h2222, 16'h0000, 1'b0,
                   1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 16'hABCD, 3'b000, 16'h1234, 16'h2222};
        vt[1]  = '{4'd0, 4'd5, 4'd6, 16'h1111, 16'h2222, 16'h0000, 1'b0,
                   1'b0, 4'd5, 16'h1234, 1'b1, 4'd5, 16'hABCD, 3'b000, 16'hABCD, 16'h2222};
        vt[2]  = '{4'd0, 4'd0, 4'd6, 16'h9999, 16'h2222, 16'h0000, 1'b0,
                   1'b1, 4'd0, 16'h5555, 1'b1, 4'd0, 16'h6666, 3'b000, 16'h0000, 16'h2222};
        vt[3]  = '{4'd2, 4'd1, 4'd2, 16'h00F0, 16'h0F00, 16'h0000, 1'b0,
                   1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 3'b011, 16'h00F0, 16'h0F00};
        vt[4]  = '{4'd3, 4'd1, 4'd2, 16'h0101, 16'h0202, 16'h8000, 1'b1,
                   1'b1, 4'd2, 16'h7777, 1'b0, 4'd0, 16'h0000, 3'b010, 16'h0101, 16'h8000};
        vt[5]  = '{4'd4, 4'd1, 4'd7, 16'h0003, 16'h0004, 16'h0000, 1'b0,
                   1'b1, 4'd6, 16'h0000, 1'b1, 4'd7, 16'hBEEF, 3'b100, 16'h0003, 16'hBEEF};
        vt[6]  = '{4'd5, 4'd1, 4'd7, 16'h0003, 16'h0004, 16'h0000, 1'b0,
                   1'b1, 4'd7, 16'hCAFE, 1'b1, 4'd7, 16'hBEEF, 3'b101, 16'h0003, 16'hCAFE};
        vt[7]  = '{4'd6, 4'd2, 4'd3, 16'hA5A5, 16'h0008, 16'h0000, 1'b0,
                   1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 3'b110, 16'hA5A5, 16'h0008};
        vt[8]  = '{4'd7, 4'd2, 4'd3, 16'h7F7F, 16'h0101, 16'h0000, 1'b0,
                   1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 3'b111, 16'h7F7F, 16'h0101};
        vt[9]  = '{4'd8, 4'd9, 4'd3, 16'h1000, 16'h0000, 16'h0024, 1'b1,
                   1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 3'b000, 16'h1000, 16'h0024};
        vt[10] = '{4'd15, 4'd3, 4'd4, 16'h3333, 16'h4444, 16'h0000, 1'b0,
                   1'b0, 4'd3, 16'hEEEE, 1'b0, 4'd3, 16'hDDDD, 3'b000, 16'h3333, 16'h4444};
        vt[11] = '{4'd1, 4'd4, 4'd0, 16'h4444, 16'hFFFF, 16'h0000, 1'b0,
                   1'b1, 4'd0, 16'h1212, 1'b0, 4'd0, 16'h0000, 3'b001, 16'h4444, 16'h0000};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; alu_flags = 3'b000;
        load(4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        fwd_off();
        #3;
        chk("rst_ex_valid", 16'(ex_valid), 16'h0);
        chk("rst_ex_reg_write", 16'(ex_reg_write), 16'h0);
        chk("rst_ex_rd", 16'(ex_rd), 16'h0);
        chk("rst_alu_op", 16'(alu_op), 16'h0);
        chk("rst_flag_reg", 16'(flag_reg), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        load(4'd0, 4'd1, 4'd2, 4'd3, 16'h7FFF, 16'h0001, 1'b1);
        alu_flags = 3'b110;
        step();
        chk("add_alu_op", 16'(alu_op), 16'h0);
        chk("add_in1", alu_in1, 16'h7FFF);
        chk("add_in2", alu_in2, 16'h0001);
        chk("add_ex_valid", 16'(ex_valid), 16'h1);
        chk("add_ex_rd", 16'(ex_rd), 16'h3);
        chk("add_ex_reg_write", 16'(ex_reg_write), 16'h1);
        chk("add_flag_before", 16'(flag_reg), 16'h0);
        load(4'd2, 4'd1, 4'd2, 4'd4, 16'h0F0F, 16'h0F0F, 1'b1);
        step();
        chk("add_flag_write", 16'(flag_reg), 16'h6);
        chk("xor_alu_op", 16'(alu_op), 16'h3);
        alu_flags = 3'b001;
        id_valid = 1'b0;
        step();
        chk("xor_flag_z_only", 16'(flag_reg), 16'h7);

        load(4'd0, 4'd1, 4'd2, 4'd3, 16'h1234, 16'h0001, 1'b1);
        step();
        chk("bubble_no_flag", 16'(flag_reg), 16'h7);
        chk("pre_rst_valid", 16'(ex_valid), 16'h1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 16'(ex_valid), 16'h0);
        chk("async_rst_regw", 16'(ex_reg_write), 16'h0);
        chk("async_rst_flags", 16'(flag_reg), 16'h0);
        chk("async_rst_in1", alu_in1, 16'h0);
        chk("async_rst_rd", 16'(ex_rd), 16'h0);
        #2 rst = 1'b0;

        alu_flags = 3'b000;
        for (int i = 0; i < 12; i++) begin
            load(vt[i].op, vt[i].rs, vt[i].rt, 4'd1, vt[i].rsd, vt[i].rtd, 1'b1);
            id_imm = vt[i].imm;
            id_use_imm = vt[i].use_imm;
            step();
            exmem_reg_write = vt[i].exw;
            exmem_rd = vt[i].exrd;
            exmem_result = vt[i].exres;
            memwb_reg_write = vt[i].mww;
            memwb_rd = vt[i].mwrd;
            memwb_result = vt[i].mwres;
            #1;
            chk($sformatf("vec%0d_op", i), 16'(alu_op), 16'(vt[i].e_op));
            chk($sformatf("vec%0d_in1", i), alu_in1, vt[i].e_in1);
            chk($sformatf("vec%0d_in2", i), alu_in2, vt[i].e_in2);
            fwd_off();
        end

        load(4'd1, 4'd4, 4'd0, 4'd4, 16'h0011, 16'h0000, 1'b1);
        step();
        alu_flags = 3'b010;
        stall = 1'b1;
        load(4'd0, 4'd9, 4'd9, 4'd9, 16'h5555, 16'h5555, 1'b1);
        step();
        chk("stall1_in1", alu_in1, 16'h0011);
        chk("stall1_op", 16'(alu_op), 16'h1);
        chk("stall1_rd", 16'(ex_rd), 16'h4);
        chk("stall1_flags", 16'(flag_reg), 16'h0);
        memwb_reg_write = 1'b1; memwb_rd = 4'd4; memwb_result = 16'h00AA;
        step();
        fwd_off();
        #1;
        chk("stall2_capture", alu_in1, 16'h00AA);
        chk("stall2_flags", 16'(flag_reg), 16'h0);
        step();
        chk("stall3_in1", alu_in1, 16'h00AA);
        chk("stall3_flags", 16'(flag_reg), 16'h0);
        stall = 1'b0;
        id_valid = 1'b0;
        step();
        chk("release_flags", 16'(flag_reg), 16'h2);
        chk("release_valid", 16'(ex_valid), 16'h0);

        load(4'd0, 4'd1, 4'd2, 4'd5, 16'h0001, 16'h0001, 1'b1);
        alu_flags = 3'b000;
        step();
        flush = 1'b1; stall = 1'b1; alu_flags = 3'b101;
        step();
        chk("flush_stall_valid", 16'(ex_valid), 16'h0);
        chk("flush_stall_regw", 16'(ex_reg_write), 16'h0);
        chk("flush_stall_flags", 16'(flag_reg), 16'h2);
        flush = 1'b0; stall = 1'b0; id_valid = 1'b0; alu_flags = 3'b111;
        step();
        chk("flush_bubble_flags", 16'(flag_reg), 16'h2);

        load(4'd0, 4'd1, 4'd2, 4'd5, 16'h0001, 16'h0001, 1'b1);
        alu_flags = 3'b000;
        step();
        flush = 1'b1; alu_flags = 3'b100;
        step();
        chk("flush_keeps_ex_flag", 16'(flag_reg), 16'h4);
        chk("flush_valid", 16'(ex_valid), 16'h0);
        flush = 1'b0;

        load(4'd3, 4'd1, 4'd2, 4'd5, 16'h0001, 16'h0001, 1'b1);
        alu_flags = 3'b111;
        step();
        chk("red_op", 16'(alu_op), 16'h2);
        load(4'd7, 4'd1, 4'd2, 4'd5, 16'h0001, 16'h0001, 1'b1);
        step();
        chk("paddsb_op", 16'(alu_op), 16'h7);
        chk("red_no_flags", 16'(flag_reg), 16'h4);
        id_valid = 1'b0;
        step();
        chk("paddsb_no_flags", 16'(flag_reg), 16'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
